// File: rtl/pe2ddr_ctrl.sv
// pe2ddr_ctrl: write-back instruction sequencer for the PE-to-DDR path.
// Latches one instruction, splits its burst sequence between the two DDR
// write ports, starts the ddr_addr_gen pair, waits for both to complete,
// then retires the instruction with a one-cycle done pulse.
// Optional feature macro: PE2DDR_CTRL_PERF_EN adds the perf_cycles counter.
module pe2ddr_ctrl #(
   parameter int DDR_ADDR_W = 32,
   parameter int BURST_W    = 8,
   parameter int INS_W      = 2*DDR_ADDR_W + 2*BURST_W + 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INS_W-1:0]      ins,
   input  logic                  ins_valid,
   output logic                  ins_ready,
   output logic                  ddr1_start,
   input  logic                  ddr1_done,
   output logic [DDR_ADDR_W-1:0] ddr1_st_addr,
   output logic [BURST_W-1:0]    ddr1_burst,
   output logic [DDR_ADDR_W-1:0] ddr1_step,
   output logic [BURST_W-1:0]    ddr1_burst_num,
   output logic                  ddr2_start,
   input  logic                  ddr2_done,
   output logic [DDR_ADDR_W-1:0] ddr2_st_addr,
   output logic [BURST_W-1:0]    ddr2_burst,
   output logic [DDR_ADDR_W-1:0] ddr2_step,
   output logic [BURST_W-1:0]    ddr2_burst_num,
   output logic                  busy,
`ifdef PE2DDR_CTRL_PERF_EN
   output logic [31:0]           perf_cycles,
`endif
   output logic                  done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_ISSUE,
      S_WAIT,
      S_FIN
   } state_t;

   state_t state, next_state;

   // Latched instruction fields
   logic [DDR_ADDR_W-1:0] st_addr_q, step_q;
   logic [BURST_W-1:0]    burst_q, bn_q;
   logic [1:0]            mode_q;

   // Outstanding generator flags
   logic pend1, pend2;

   // Split results, valid while in CALC
   logic [BURST_W:0]      n1;
   logic [BURST_W-1:0]    cnt1, cnt2;
   logic [DDR_ADDR_W-1:0] addr2;

   assign ins_ready = (state == S_IDLE);

   // Burst split and next-state decode
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      next_state = state;
      n1         = ({1'b0, bn_q} + (BURST_W+1)'(1)) >> 1;
      cnt1       = '0;
      cnt2       = '0;
      addr2      = st_addr_q;
      case (mode_q)
         2'b01: cnt1 = bn_q;
         2'b10: cnt2 = bn_q;
         2'b11: begin
            // Port 1 takes the larger half; port 2 resumes n1 strides later.
            cnt1  = BURST_W'(n1);
            cnt2  = bn_q >> 1;
            addr2 = st_addr_q + step_q * DDR_ADDR_W'(n1);
         end
         default: ;
      endcase

      case (state)
         S_IDLE:  if (ins_valid) next_state = S_CALC;
         S_CALC:  next_state = ((cnt1 != '0) || (cnt2 != '0)) ? S_ISSUE : S_FIN;
         S_ISSUE: next_state = S_WAIT;
         S_WAIT:  if (!pend1 && !pend2) next_state = S_FIN;
         S_FIN:   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst) state <= S_IDLE;
      else      state <= next_state;
   end

   // Instruction latch, port configuration, start pulses and pending flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_addr_q      <= '0;
         step_q         <= '0;
         burst_q        <= '0;
         bn_q           <= '0;
         mode_q         <= '0;
         pend1          <= 1'b0;
         pend2          <= 1'b0;
         ddr1_start     <= 1'b0;
         ddr2_start     <= 1'b0;
         ddr1_st_addr   <= '0;
         ddr1_burst     <= '0;
         ddr1_step      <= '0;
         ddr1_burst_num <= '0;
         ddr2_st_addr   <= '0;
         ddr2_burst     <= '0;
         ddr2_step      <= '0;
         ddr2_burst_num <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         ddr1_start <= 1'b0;
         ddr2_start <= 1'b0;
         busy       <= (next_state != S_IDLE);
         done       <= (next_state == S_FIN);

         if (state == S_IDLE && ins_valid) begin
            st_addr_q <= ins[DDR_ADDR_W-1:0];
            step_q    <= ins[2*DDR_ADDR_W-1:DDR_ADDR_W];
            burst_q   <= ins[2*DDR_ADDR_W+BURST_W-1:2*DDR_ADDR_W];
            bn_q      <= ins[2*DDR_ADDR_W+2*BURST_W-1:2*DDR_ADDR_W+BURST_W];
            mode_q    <= ins[2*DDR_ADDR_W+2*BURST_W+1:2*DDR_ADDR_W+2*BURST_W];
         end

         if (state == S_CALC) begin
            ddr1_st_addr   <= st_addr_q;
            ddr1_burst     <= burst_q;
            ddr1_step      <= step_q;
            ddr1_burst_num <= cnt1;
            ddr2_st_addr   <= addr2;
            ddr2_burst     <= burst_q;
            ddr2_step      <= step_q;
            ddr2_burst_num <= cnt2;
            ddr1_start     <= (cnt1 != '0);
            ddr2_start     <= (cnt2 != '0);
         end

         // Dones outside WAIT, or for an idle port, leave the flags untouched.
         if (state == S_ISSUE) begin
            pend1 <= ddr1_start;
            pend2 <= ddr2_start;
         end else if (state == S_WAIT) begin
            if (ddr1_done) pend1 <= 1'b0;
            if (ddr2_done) pend2 <= 1'b0;
         end
      end
   end

`ifdef PE2DDR_CTRL_PERF_EN
   // Saturating count of busy cycles since reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                              perf_cycles <= '0;
      else if (busy && perf_cycles != '1)    perf_cycles <= perf_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_pe2ddr_ctrl.sv
// tb_pe2ddr_ctrl: directed and randomized checks of pe2ddr_ctrl against a
// cycle-level behavioural model of split, timing and retirement.
// Optional feature macro: PE2DDR_CTRL_PERF_EN enables perf_cycles checks.
module tb_pe2ddr_ctrl;

   localparam int AW = 32;
   localparam int BW = 8;
   localparam int IW = 2*AW + 2*BW + 2;

   logic          clk;
   logic          rst;
   logic [IW-1:0] ins;
   logic          ins_valid;
   logic          ins_ready;
   logic          ddr1_start, ddr1_done, ddr2_start, ddr2_done;
   logic [AW-1:0] ddr1_st_addr, ddr1_step, ddr2_st_addr, ddr2_step;
   logic [BW-1:0] ddr1_burst, ddr1_burst_num, ddr2_burst, ddr2_burst_num;
   logic          busy, done;
`ifdef PE2DDR_CTRL_PERF_EN
   logic [31:0]   perf_cycles;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   longint exp_perf = 0;

   pe2ddr_ctrl #(.DDR_ADDR_W(AW), .BURST_W(BW), .INS_W(IW)) dut (
      .clk            (clk),
      .rst            (rst),
      .ins            (ins),
      .ins_valid      (ins_valid),
      .ins_ready      (ins_ready),
      .ddr1_start     (ddr1_start),
      .ddr1_done      (ddr1_done),
      .ddr1_st_addr   (ddr1_st_addr),
      .ddr1_burst     (ddr1_burst),
      .ddr1_step      (ddr1_step),
      .ddr1_burst_num (ddr1_burst_num),
      .ddr2_start     (ddr2_start),
      .ddr2_done      (ddr2_done),
      .ddr2_st_addr   (ddr2_st_addr),
      .ddr2_burst     (ddr2_burst),
      .ddr2_step      (ddr2_step),
      .ddr2_burst_num (ddr2_burst_num),
      .busy           (busy),
`ifdef PE2DDR_CTRL_PERF_EN
      .perf_cycles    (perf_cycles),
`endif
      .done           (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout, required end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_perf();
`ifdef PE2DDR_CTRL_PERF_EN
      check("perf_cycles", perf_cycles, exp_perf[31:0]);
`endif
   endtask

   // Runs one instruction from acceptance to return to IDLE.
   // d1/d2: cycle (relative to acceptance) at which each active generator finishes.
   task automatic run_ins(input logic [1:0] mode, input logic [31:0] st, input logic [31:0] step,
                          input logic [7:0] burst, input logic [7:0] bn, input int d1, input int d2);
      int            n1, n2, exp_done, last;
      logic [31:0]   a2;
      case (mode)
         2'd1:    begin n1 = bn;           n2 = 0;      end
         2'd2:    begin n1 = 0;            n2 = bn;     end
         2'd3:    begin n1 = (bn + 1) / 2; n2 = bn / 2; end
         default: begin n1 = 0;            n2 = 0;      end
      endcase
      a2 = (mode == 2'd3) ? 32'((longint'(st) + longint'(step) * n1) % (64'd1 << 32)) : st;
      last = 0;
      if (n1 != 0 && d1 > last) last = d1;
      if (n2 != 0 && d2 > last) last = d2;
      exp_done = (n1 == 0 && n2 == 0) ? 2 : last + 2;

      // Cycle 0: offer and accept
      check("ready_c0", ins_ready, 1'b1);
      check("busy_c0", busy, 1'b0);
      ins       = {mode, bn, burst, step, st};
      ins_valid = 1'b1;
      for (int cyc = 1; cyc <= exp_done + 1; cyc++) begin
         tick();
         ins_valid = 1'b0;
         ins       = '0;
         ddr1_done = (n1 != 0) ? (cyc == d1) : (exp_done > 3 && cyc == 3);
         ddr2_done = (n2 != 0) ? (cyc == d2) : (exp_done > 3 && cyc == 3);
         check("start1", ddr1_start, (cyc == 2) && (n1 != 0));
         check("start2", ddr2_start, (cyc == 2) && (n2 != 0));
         check("done",   done, cyc == exp_done);
         check("busy",   busy, cyc <= exp_done);
         check("ready",  ins_ready, cyc == exp_done + 1);
         if (cyc == 2 || cyc == exp_done) begin
            check("ddr1_burst_num", ddr1_burst_num, n1);
            check("ddr2_burst_num", ddr2_burst_num, n2);
            check("ddr1_burst", ddr1_burst, burst);
            check("ddr2_burst", ddr2_burst, burst);
            check("ddr1_step", ddr1_step, step);
            check("ddr2_step", ddr2_step, step);
            if (n1 != 0) check("ddr1_st_addr", ddr1_st_addr, st);
            if (n2 != 0) check("ddr2_st_addr", ddr2_st_addr, a2);
         end
      end
      ddr1_done = 1'b0;
      ddr2_done = 1'b0;
      exp_perf += exp_done;
      check_perf();
   endtask

   initial begin
      logic [1:0] r_mode;
      logic [7:0] r_bn;
      int         r_d1, r_d2;

      rst       = 1'b0;
      ins       = '0;
      ins_valid = 1'b0;
      ddr1_done = 1'b0;
      ddr2_done = 1'b0;
      #12;
      // Reset state
      check("rst_ready", ins_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_start1", ddr1_start, 1'b0);
      check("rst_cfg", {ddr1_burst_num, ddr2_burst_num, ddr2_st_addr}, 48'h0);
      check_perf();
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Directed cases
      run_ins(2'd1, 32'h1000, 32'h40, 8'd16, 8'd4, 10, 0);
      run_ins(2'd3, 32'h2000, 32'h100, 8'd8, 8'd5, 9, 14);
      run_ins(2'd3, 32'h3000, 32'h20, 8'd4, 8'd1, 5, 5);
      run_ins(2'd0, 32'h4000, 32'h20, 8'd4, 8'd9, 5, 5);
      run_ins(2'd2, 32'h5000, 32'h20, 8'd4, 8'd0, 5, 5);
      run_ins(2'd2, 32'h6000, 32'h80, 8'd2, 8'd3, 3, 3);
      run_ins(2'd3, 32'h7000, 32'h10, 8'd1, 8'd6, 7, 7);
      run_ins(2'd3, 32'hFFFFFF00, 32'h100, 8'd4, 8'd4, 6, 8);
      run_ins(2'd3, 32'h0, 32'h4, 8'd1, 8'd255, 4, 3);

      // Stray ddr2_done while idle
      ddr2_done = 1'b1;
      tick();
      ddr2_done = 1'b0;
      check("stray_busy", busy, 1'b0);
      check("stray_ready", ins_ready, 1'b1);
      tick();
      check("stray_done", done, 1'b0);

      // Reset in the middle of WAIT
      ins       = {2'd3, 8'd6, 8'd4, 32'h40, 32'h9000};
      ins_valid = 1'b1;
      tick();
      ins_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("pre_rst_busy", busy, 1'b1);
      rst = 1'b0;
      #2;
      check("mid_rst_ready", ins_ready, 1'b1);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_starts", {ddr1_start, ddr2_start, done}, 3'b000);
      check("mid_rst_cfg1", {ddr1_st_addr, ddr1_step, ddr1_burst, ddr1_burst_num}, 80'h0);
      check("mid_rst_cfg2", {ddr2_st_addr, ddr2_step, ddr2_burst, ddr2_burst_num}, 80'h0);
      exp_perf = 0;
      check_perf();
      @(negedge clk);
      rst = 1'b1;
      tick();
      check("post_rst_ready", ins_ready, 1'b1);
      // Late completion from the abandoned generator
      ddr1_done = 1'b1;
      ddr2_done = 1'b1;
      tick();
      ddr1_done = 1'b0;
      ddr2_done = 1'b0;
      check("late_done_busy", busy, 1'b0);
      tick();
      check("late_done_done", done, 1'b0);
      run_ins(2'd1, 32'hA000, 32'h40, 8'd16, 8'd2, 4, 0);

      // Randomized instructions
      for (int k = 0; k < 40; k++) begin
         r_mode = 2'($urandom_range(0, 3));
         r_bn   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
         r_d1   = $urandom_range(3, 12);
         r_d2   = ($urandom_range(0, 3) == 0) ? r_d1 : $urandom_range(3, 12);
         run_ins(r_mode, $urandom, $urandom, 8'($urandom_range(0, 255)), r_bn, r_d1, r_d2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
